// File: rtl/prefetcher_pkg.sv
// Shared types and defaults for the sequential prefetch engine.
package prefetcher_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 16;

    localparam logic [ADDR_W-1:0] DEF_CACHE_BASE  = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] DEF_STRBUF_BASE = 32'h0000_2000;
    localparam logic [ADDR_W-1:0] DEF_DEST_BASE   = 32'h0000_3000;
    localparam logic [ADDR_W-1:0] DEF_STRIDE      = 32'd4;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_REQ   = 4'd1,
        ST_WAIT  = 4'd2,
        ST_WRITE = 4'd3,
        ST_DONE  = 4'd4
    } state_t;

    // base + idx*stride, wrapping at 32 bits
    function automatic logic [ADDR_W-1:0] stride_addr(input logic [ADDR_W-1:0] base,
                                                      input logic [IDX_W-1:0]  idx,
                                                      input logic [ADDR_W-1:0] stride);
        return base + ADDR_W'(idx) * stride;
    endfunction

endpackage

// File: rtl/prefetcher_port.sv
// One read port: request handshake, accept/capture tracking, data register
// and address generator. Next-state flags/data are exported so the
// controller can advance on the same edge that completes a handshake.
module prefetch_port
    import prefetcher_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE   = DEF_CACHE_BASE,
    parameter logic [ADDR_W-1:0] STRIDE = DEF_STRIDE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic [IDX_W-1:0]  issue_idx_i,
    input  logic              wait_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              acc_d_o,
    output logic              cap_d_o,
    output logic [DATA_W-1:0] data_d_o
);

    logic              req_q, req_d;
    logic              acc_q, acc_d;
    logic              cap_q, cap_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              accept_now, capture;

    // Handshake bookkeeping; a new issue clears the previous iteration's flags.
    always_comb begin
        accept_now = req_q & (wait_i | ready_i);
        // data is only wanted while this iteration's read is outstanding
        capture    = (req_q | acc_q) & ~cap_q & ready_i;
        req_d      = issue_i ? 1'b1 : (req_q & ~accept_now);
        acc_d      = issue_i ? 1'b0 : (acc_q | accept_now);
        cap_d      = issue_i ? 1'b0 : (cap_q | capture);
        data_d     = capture ? data_i : data_q;
        addr_d     = issue_i ? stride_addr(BASE, issue_idx_i, STRIDE) : addr_q;
    end

    // Port state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            acc_q  <= 1'b0;
            cap_q  <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            req_q  <= req_d;
            acc_q  <= acc_d;
            cap_q  <= cap_d;
            data_q <= data_d;
            addr_q <= addr_d;
        end
    end

    assign req_o    = req_q;
    assign addr_o   = addr_q;
    assign acc_d_o  = acc_d;
    assign cap_d_o  = cap_d;
    assign data_d_o = data_d;

endmodule

// File: rtl/prefetcher_top.sv
// Prefetch engine: per trigger, NUM_LOADS iterations of cache + store-buffer
// reads followed by one merged (summed) write-out.
module prefetcher_top
    import prefetcher_pkg::*;
#(
    parameter int unsigned       NUM_LOADS   = 10,
    parameter logic [ADDR_W-1:0] CACHE_BASE  = DEF_CACHE_BASE,
    parameter logic [ADDR_W-1:0] STRBUF_BASE = DEF_STRBUF_BASE,
    parameter logic [ADDR_W-1:0] DEST_BASE   = DEF_DEST_BASE,
    parameter logic [ADDR_W-1:0] STRIDE      = DEF_STRIDE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    output logic              cache_data_req_o,
    output logic [ADDR_W-1:0] cache_r_addr_o,
    output logic              strBuf_data_req_o,
    output logic [ADDR_W-1:0] strBuf_r_addr_o,
    input  logic              wait_cache,
    input  logic              wait_strBuf,
    input  logic              cache_data_ready,
    input  logic              strBuf_data_ready,
    input  logic [DATA_W-1:0] cache_data_i,
    input  logic [DATA_W-1:0] strBuf_data_i,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic [3:0]        outState
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LOADS);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              issue;
    logic              c_acc_d, c_cap_d, s_acc_d, s_cap_d;
    logic [DATA_W-1:0] c_data_d, s_data_d;

    prefetch_port #(.BASE(CACHE_BASE), .STRIDE(STRIDE)) u_cache (
        .clk         (clk),
        .rst_n       (reset),
        .issue_i     (issue),
        .issue_idx_i (idx_d),
        .wait_i      (wait_cache),
        .ready_i     (cache_data_ready),
        .data_i      (cache_data_i),
        .req_o       (cache_data_req_o),
        .addr_o      (cache_r_addr_o),
        .acc_d_o     (c_acc_d),
        .cap_d_o     (c_cap_d),
        .data_d_o    (c_data_d)
    );

    prefetch_port #(.BASE(STRBUF_BASE), .STRIDE(STRIDE)) u_strbuf (
        .clk         (clk),
        .rst_n       (reset),
        .issue_i     (issue),
        .issue_idx_i (idx_d),
        .wait_i      (wait_strBuf),
        .ready_i     (strBuf_data_ready),
        .data_i      (strBuf_data_i),
        .req_o       (strBuf_data_req_o),
        .addr_o      (strBuf_r_addr_o),
        .acc_d_o     (s_acc_d),
        .cap_d_o     (s_cap_d),
        .data_d_o    (s_data_d)
    );

    // Next-state logic; write-out is loaded on the edge entering WRITE so it
    // is valid for the whole WRITE cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        issue    = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                    issue   = 1'b1;
                end
            end
            ST_REQ: begin
                if (c_acc_d && s_acc_d) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (c_cap_d && s_cap_d) begin
                    state_d  = ST_WRITE;
                    w_addr_d = stride_addr(DEST_BASE, idx_q, STRIDE);
                    w_data_d = c_data_d + s_data_d;
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + 1'b1;
                if (idx_d == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                    issue   = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;
    assign outState = state_q;

endmodule

// File: tb/tb_prefetcher_top.sv
// Self-checking bench: responder models for both read ports plus a scoreboard
// of expected requests and merged writes, with directed and random runs.
module tb_prefetcher_top;

    localparam int NL = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0;
    logic        c_req, s_req;
    logic [31:0] c_addr, s_addr, w_addr, w_data;
    logic [3:0]  st;
    logic        wait_c = 1'b0, wait_s = 1'b0, rdy_c = 1'b0, rdy_s = 1'b0;
    logic [31:0] dat_c = '0, dat_s = '0;

    always #5 clk = ~clk;

    prefetcher_top #(
        .NUM_LOADS(NL), .CACHE_BASE(32'h1000), .STRBUF_BASE(32'h2000),
        .DEST_BASE(32'h3000), .STRIDE(32'd4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .trigger           (trigger),
        .cache_data_req_o  (c_req),
        .cache_r_addr_o    (c_addr),
        .strBuf_data_req_o (s_req),
        .strBuf_r_addr_o   (s_addr),
        .wait_cache        (wait_c),
        .wait_strBuf       (wait_s),
        .cache_data_ready  (rdy_c),
        .strBuf_data_ready (rdy_s),
        .cache_data_i      (dat_c),
        .strBuf_data_i     (dat_s),
        .w_addr_o          (w_addr),
        .w_data_o          (w_data),
        .outState          (st)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Reference data: word returned for iteration n on port p (0=cache, 1=strbuf)
    logic [31:0] wmem [2][16];
    int  reqn [2];
    int  wn;
    int  lat_cfg [2];
    bit  direct [2];
    int  adly_max;
    bit  rec_en = 1'b0;
    int  stq [$];

    // responder state
    bit  seen [2];
    bit  pend [2];
    int  lcnt [2];
    int  adly [2];
    int  pidx [2];

    // Scoreboard of writes plus the two port responders, all on the falling edge.
    always @(negedge clk) begin
        logic        rq [2];
        logic [31:0] ad [2];
        logic [31:0] base [2];
        logic        wt [2];
        logic        rd [2];
        logic [31:0] dv [2];
        rq[0] = c_req;  rq[1] = s_req;
        ad[0] = c_addr; ad[1] = s_addr;
        base[0] = 32'h1000; base[1] = 32'h2000;
        dv[0] = dat_c; dv[1] = dat_s;

        if (st == 4'd3) begin
            chk("w_addr", w_addr, 32'h3000 + 32'(4 * wn));
            chk("w_data", w_data, wmem[0][wn % 16] + wmem[1][wn % 16]);
            wn++;
        end
        if (rec_en) stq.push_back(int'(st));

        for (int p = 0; p < 2; p++) begin
            wt[p] = 1'b0;
            rd[p] = 1'b0;
            if (pend[p]) begin
                lcnt[p]--;
                if (lcnt[p] <= 0) begin
                    rd[p] = 1'b1;
                    dv[p] = wmem[p][pidx[p] % 16];
                    pend[p] = 1'b0;
                end
            end
            if (!rq[p]) begin
                seen[p] = 1'b0;
            end else begin
                if (!seen[p]) begin
                    seen[p] = 1'b1;
                    // request n may only appear once write n-1 has happened
                    chk(p == 0 ? "c_req_order" : "s_req_order", 32'(reqn[p]), 32'(wn));
                    pidx[p] = reqn[p];
                    reqn[p]++;
                    adly[p] = $urandom_range(adly_max, 0);
                end
                chk(p == 0 ? "c_addr" : "s_addr", ad[p], base[p] + 32'(4 * pidx[p]));
                if (adly[p] > 0) begin
                    adly[p]--;
                end else if (!pend[p] && !rd[p]) begin
                    if (direct[p]) begin
                        rd[p] = 1'b1;
                        dv[p] = wmem[p][pidx[p] % 16];
                    end else begin
                        wt[p]   = 1'b1;
                        pend[p] = 1'b1;
                        lcnt[p] = (lat_cfg[p] > 0) ? lat_cfg[p] : int'($urandom_range(5, 1));
                    end
                end
            end
        end
        wait_c = wt[0]; rdy_c = rd[0]; dat_c = dv[0];
        wait_s = wt[1]; rdy_s = rd[1]; dat_s = dv[1];
    end

    task automatic pulse_trigger();
        @(negedge clk); #1; trigger = 1'b1;
        @(negedge clk); #1; trigger = 1'b0;
    endtask

    // One full run; poke=1 throws trigger pulses at WAIT (random) and DONE (always).
    task automatic run(input bit poke);
        bit done;
        wn = 0; reqn[0] = 0; reqn[1] = 0;
        pulse_trigger();
        done = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(negedge clk); #1;
            trigger = 1'b0;
            if (wn >= NL && st == 4'd0) done = 1'b1;
            else if (poke && (st == 4'd4 || (st == 4'd2 && $urandom_range(1, 0) == 1))) trigger = 1'b1;
        end
        trigger = 1'b0;
        chk("run_done", 32'(done), 32'd1);
        chk("write_count", 32'(wn), 32'(NL));
        repeat (3) @(negedge clk);
        #1;
        chk("stay_idle", 32'(st), 32'd0);
        chk("no_extra_writes", 32'(wn), 32'(NL));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_creq"}, 32'(c_req), 32'd0);
        chk({tag, "_caddr"}, c_addr, 32'd0);
        chk({tag, "_sreq"}, 32'(s_req), 32'd0);
        chk({tag, "_saddr"}, s_addr, 32'd0);
        chk({tag, "_waddr"}, w_addr, 32'd0);
        chk({tag, "_wdata"}, w_data, 32'd0);
        chk({tag, "_state"}, 32'(st), 32'd0);
    endtask

    task automatic rand_data();
        for (int k = 0; k < 16; k++) begin
            wmem[0][k] = $urandom;
            wmem[1][k] = $urandom;
        end
    endtask

    initial begin
        int eq [$];
        int cq [$];
        int n3, n4;
        bit found;
        adly_max = 0;
        lat_cfg[0] = 3; lat_cfg[1] = 3;
        direct[0] = 1'b0; direct[1] = 1'b0;
        wn = 0; reqn[0] = 0; reqn[1] = 0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check_zero("rst");
        reset = 1'b1;

        // A: latency 3 on both ports, fixed data
        for (int k = 0; k < 16; k++) begin
            wmem[0][k] = 32'h10 + 32'(k);
            wmem[1][k] = 32'h100 + 32'(k);
        end
        run(1'b0);
        chk("A_last_waddr", w_addr, 32'h3024);
        chk("A_last_wdata", w_data, 32'h122);
        chk("A_last_caddr", c_addr, 32'h1024);
        chk("A_last_saddr", s_addr, 32'h2024);

        // B: skewed returns, cache fast, store buffer slow
        rand_data();
        lat_cfg[0] = 1; lat_cfg[1] = 5;
        run(1'b0);

        // C: ready without wait while req is high
        rand_data();
        direct[0] = 1'b1; direct[1] = 1'b1;
        run(1'b0);

        // D: trigger pulses during WAIT and DONE, state sequence recorded
        rand_data();
        direct[0] = 1'b0; direct[1] = 1'b0;
        lat_cfg[0] = 0; lat_cfg[1] = 0;
        adly_max = 2;
        stq.delete();
        rec_en = 1'b1;
        run(1'b1);
        rec_en = 1'b0;
        eq.push_back(0);
        for (int i = 0; i < NL; i++) begin
            eq.push_back(1); eq.push_back(2); eq.push_back(3);
        end
        eq.push_back(4);
        eq.push_back(0);
        n3 = 0; n4 = 0;
        foreach (stq[i]) begin
            if (i == 0 || stq[i] != stq[i-1]) cq.push_back(stq[i]);
            if (stq[i] == 3) n3++;
            if (stq[i] == 4) n4++;
        end
        chk("seq_len", 32'(cq.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size() && i < cq.size(); i++) chk("seq_state", 32'(cq[i]), 32'(eq[i]));
        chk("write_cycles", 32'(n3), 32'(NL));
        chk("done_cycles", 32'(n4), 32'd1);

        // E: reset mid-WAIT of iteration 4, then a clean restart
        rand_data();
        adly_max = 1;
        wn = 0; reqn[0] = 0; reqn[1] = 0;
        pulse_trigger();
        found = 1'b0;
        for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
            @(negedge clk); #1;
            if (wn == 4 && st == 4'd2) found = 1'b1;
        end
        chk("E_reach_wait", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        check_zero("midrst");
        repeat (8) @(negedge clk);
        #1;
        check_zero("midrst_hold");
        reset = 1'b1;
        run(1'b0);

        // F: 32-bit wrap of the merged sum
        for (int k = 0; k < 16; k++) begin
            wmem[0][k] = 32'hFFFF_FFFF;
            wmem[1][k] = 32'h0000_0002;
        end
        adly_max = 0;
        run(1'b0);
        chk("ovf_wdata", w_data, 32'h0000_0001);

        // G: random mixes of handshake style, latency and data
        for (int r = 0; r < 3; r++) begin
            rand_data();
            direct[0] = 1'($urandom_range(1, 0));
            direct[1] = 1'($urandom_range(1, 0));
            adly_max = 2;
            run(r == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prefetcher_top.md
Name: prefetcher_top

Overview:
Sequential prefetch engine. One `trigger` pulse starts a run of NUM_LOADS iterations. Each iteration issues one read to the data cache and one to the store buffer, collects both returned words, and emits a merged write (`w_addr_o`/`w_data_o`). It sits between the core-side control and the cache/store-buffer read ports, and exposes its FSM state on `outState` for debug.

Parameters:
NUM_LOADS, 10, iterations per trigger (1..2^16-1)
CACHE_BASE, 32'h0000_1000, first cache read address
STRBUF_BASE, 32'h0000_2000, first store-buffer read address
DEST_BASE, 32'h0000_3000, first write-out address
STRIDE, 32'd4, per-iteration address increment for all three streams

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset)
trigger  in  1  one-cycle start pulse
cache_data_req_o  out  1  cache read request
cache_r_addr_o  out  32  cache read address
strBuf_data_req_o  out  1  store-buffer read request
strBuf_r_addr_o  out  32  store-buffer read address
wait_cache  in  1  cache accepted request, busy
wait_strBuf  in  1  store buffer accepted request, busy
cache_data_ready  in  1  one-cycle pulse, cache_data_i valid
strBuf_data_ready  in  1  one-cycle pulse, strBuf_data_i valid
cache_data_i  in  32  cache read data
strBuf_data_i  in  32  store-buffer read data
w_addr_o  out  32  write-out address
w_data_o  out  32  write-out data
outState  out  4  current FSM state code

Behaviour:
- Reset (reset=0, async): state IDLE; idx=0; all outputs 0; internal pending/captured flags cleared. Reset mid-run aborts the run with no further requests.
- States and codes: IDLE=0, REQ=1, WAIT=2, WRITE=3, DONE=4. `outState` equals the registered state code.
- IDLE: on `trigger`=1 at a rising edge -> REQ, idx=0. `trigger` is ignored in every other state.
- REQ:
  - Both req outputs are asserted from the edge entering REQ.
  - `cache_r_addr_o` = CACHE_BASE + idx*STRIDE; `strBuf_r_addr_o` = STRBUF_BASE + idx*STRIDE (32-bit wrap).
  - Each req stays high until its own accept is sampled. Accept = wait_x=1 or ready_x=1. It then drops independently.
  - When both requests are accepted -> WAIT.
  - A ready pulse sampled in REQ also captures its data.
- Addresses hold stable while the corresponding req is high. Once req drops, the address holds its last value.
- WAIT:
  - Capture cache_data_i on the cycle `cache_data_ready`=1, and strBuf_data_i on the cycle `strBuf_data_ready`=1.
  - The two ports may return in any order or in the same cycle. The wait_x level is otherwise ignored.
  - When both words are captured -> WRITE.
  - Ready for a port already captured, or arriving with no outstanding request, is ignored.
- WRITE (exactly one cycle):
  - `w_addr_o` = DEST_BASE + idx*STRIDE; `w_data_o` = cache_word + strBuf_word (mod 2^32). Both are registered and hold until the next WRITE.
  - `outState`=3 is the write strobe.
  - idx++. If idx==NUM_LOADS -> DONE, else -> REQ.
- DONE: one cycle, then IDLE. A trigger sampled in DONE is ignored.
- No combinational path from any input to any output.

Decomposition:
- Shared package `prefetcher_pkg`:
  - `state_t` enum (4-bit, codes above)
  - `ADDR_W`=32, `DATA_W`=32
  - default base/stride constants
- Natural sub-module: `prefetch_port`, instanced twice (cache, store buffer). It holds per-port req/accepted/captured flags, the data register, and the address generator.

Test Plan:
- Single run, latency 3, both ports together. Reset 2 cycles, trigger. Required:
  - Requests at addresses 0x1000/0x2000, 0x1004/0x2004 … 0x1024/0x2024.
  - cache data 0x10+n, strBuf data 0x100+n -> w_addr_o=0x3000+4n, w_data_o=0x110+2n.
  - DONE after 10 WRITEs, then IDLE.
- Skewed returns: cache ready 1 cycle, strBuf ready 5 cycles -> single WRITE only after both; w_data_o correct sum; no new request issued early.
- Same-cycle accept+ready without wait (ready_x=1 while req high) -> data captured, req drops, iteration completes.
- Trigger pulses during WAIT and DONE -> ignored; exactly NUM_LOADS writes; outState sequence 0,1,2,3,…,4,0.
- reset=0 asserted mid-WAIT (iteration 4) -> all outputs 0 immediately; after release plus trigger, run restarts at 0x1000/0x2000.
- Overflow: cache 0xFFFF_FFFF + strBuf 0x0000_0002 -> w_data_o=0x0000_0001.
